tdm_demux_rx: RTL and testbench
===============================

Name: tdm_demux_rx

Overview:
- Receive end of the team's time-division multiplexed link: takes one serial word stream carrying NCH channel slots per frame and distributes each slot to its own parallel output lane.
- Frame-locked via a slot-0 sync marker.
- Buffers a full frame in shadow registers and presents all channels together with a one-cycle frame strobe.
- Detects sync loss and resynchronises.

Parameters:
- WIDTH, 8, bits per channel word
- NCH, 4, channel slots per frame (>=2)
- CW, $clog2(NCH), slot counter width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- din  input  WIDTH  multiplexed data word
- din_valid  input  1  din carries a slot word this cycle
- fsync  input  1  qualifies din as slot 0 of a frame; ignored when din_valid=0
- dout  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; holds last complete frame
- frame_valid  output  1  one-cycle pulse: dout just updated
- locked  output  1  receiver is frame-locked
- slot  output  CW  index of the next expected slot
- sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (rst_n=0 at an edge): state=HUNT; slot=0; dout, shadow, frame_valid, locked, sync_err all 0. Reset mid-frame discards the partial frame; dout is also cleared.
- All outputs are registered. Any edge with din_valid=0 changes nothing, except that frame_valid and sync_err return to 0.
- HUNT:
  - din_valid & fsync -> shadow[0]<=din; slot<=1; state<=LOCK; locked<=1.
  - din_valid & !fsync -> word discarded; no error.
- LOCK, din_valid=1:
  - slot!=0 & !fsync -> shadow[slot]<=din. If slot==NCH-1: dout<={din, shadow[NCH-2..0]}, frame_valid<=1, slot<=0. Otherwise slot<=slot+1.
  - slot==0 & fsync -> shadow[0]<=din; slot<=1.
  - slot!=0 & fsync (early sync) -> sync_err<=1; partial frame dropped, dout unchanged; din taken as the new slot 0: shadow[0]<=din, slot<=1; stays LOCK.
  - slot==0 & !fsync (missing sync) -> sync_err<=1; word discarded; state<=HUNT; locked<=0; slot<=0; dout keeps its last frame.
- Latency: dout and frame_valid update on the same edge that samples the last slot word (visible 1 cycle after that word is presented).
- Back-to-back frames with no idle cycles are supported. frame_valid may pulse on consecutive frames only NCH valid words apart.
- Slot counter wraps NCH-1 -> 0 only through the frame-complete path; it never exceeds NCH-1.
- sync_err and frame_valid are never both 1: only one path fires per word.

Decomposition:
- Shared package tdm_pkg holds:
  - state encoding HUNT=1'b0, LOCK=1'b1
  - default NCH and WIDTH constants, reused by the matching tdm_mux_tx transmitter
- One natural sub-module, tdm_slot_ctr: CW-bit counter with load-to-1, clear, increment and terminal-count flag (slot==NCH-1).
- Shadow/dout storage and the FSM stay in tdm_demux_rx.

Test Plan:
- Reset then lock: hold rst_n=0 for 2 edges, check all outputs 0. Send fsync+A1, then B2, C3, D4 with valid every cycle -> frame_valid pulses once after D4; dout=0xD4C3B2A1; locked=1; slot=0.
- Gapped and back-to-back: the same frame with din_valid=0 gaps of 1-3 cycles, then frame 11,22,33,44 immediately following -> frame_valid exactly twice; dout=0x44332211 at the end; no sync_err.
- Early sync: fsync+A1, B2, then fsync+55, 66, 77, 88 -> sync_err pulse on the 55 edge; no frame_valid for the A1 frame; then dout=0x88776655, frame_valid once, locked stays 1.
- Missing sync: after a good frame, send 99 without fsync at slot 0 -> sync_err pulse; locked=0; dout unchanged. Words without fsync stay ignored until fsync+10,20,30,40 -> dout=0x40302010.
- Hunt ignore: from reset, send 5 valid words without fsync -> locked=0; no sync_err; dout=0.
- Reset mid-frame: fsync+A1, B2, then rst_n=0 for one edge, then C3, D4 without fsync -> everything 0; locked=0; no frame_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: receiver state encoding and default frame geometry.
// The transmitter side reuses the same defaults so both ends agree on the frame shape.
package tdm_pkg;

    localparam int unsigned DefaultNch   = 4;
    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        StHunt = 1'b0,
        StLock = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for a TDM frame: clear, load-to-1 and increment, with a flag that
// marks the last slot of the frame.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = DefaultNch,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          load1_i,
    input  logic          inc_i,
    output logic [CW-1:0] slot_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] LastSlot = CW'(NCH - 1);

    logic [CW-1:0] slot_d, slot_q;

    // Clear wins over load, load over increment; wrap only happens via clear.
    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = CW'(1);
        end else if (inc_i) begin
            slot_d = slot_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign tc_o   = (slot_q == LastSlot);

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: locks onto the slot-0 sync marker, collects a frame in shadow registers and
// publishes all channels at once with a single-cycle frame strobe.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned NCH   = DefaultNch,
    parameter int unsigned CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 fsync,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 frame_valid,
    output logic                 locked,
    output logic [CW-1:0]        slot,
    output logic                 sync_err
);

    tdm_state_e state_d, state_q;

    logic [NCH-1:0][WIDTH-1:0] shadow_d, shadow_q;
    logic [NCH-1:0][WIDTH-1:0] dout_d, dout_q;
    logic                      frame_valid_d, frame_valid_q;
    logic                      sync_err_d, sync_err_q;

    logic          ctr_clr, ctr_load1, ctr_inc, ctr_tc;
    logic [CW-1:0] slot_q;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic          frame_done;

    tdm_slot_ctr #(
        .NCH (NCH),
        .CW  (CW)
    ) u_slot_ctr (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (ctr_clr),
        .load1_i (ctr_load1),
        .inc_i   (ctr_inc),
        .slot_o  (slot_q),
        .tc_o    (ctr_tc)
    );

    // Exactly one path fires per valid word, so sync_err and frame_valid are exclusive.
    always_comb begin
        state_d       = state_q;
        ctr_clr       = 1'b0;
        ctr_load1     = 1'b0;
        ctr_inc       = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = '0;
        frame_done    = 1'b0;
        sync_err_d    = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (fsync) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                        state_d   = StLock;
                    end
                end
                StLock: begin
                    if (slot_q != '0 && !fsync) begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        if (ctr_tc) begin
                            frame_done = 1'b1;
                            ctr_clr    = 1'b1;
                        end else begin
                            ctr_inc = 1'b1;
                        end
                    end else if (slot_q == '0 && fsync) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                    end else if (fsync) begin
                        // Early sync: drop the partial frame and restart on this word.
                        sync_err_d = 1'b1;
                        wr_en      = 1'b1;
                        ctr_load1  = 1'b1;
                    end else begin
                        sync_err_d = 1'b1;
                        ctr_clr    = 1'b1;
                        state_d    = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_idx] = din;
        end
    end

    // The last word goes straight to dout; its shadow copy is not needed for this frame.
    always_comb begin
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        if (frame_done) begin
            dout_d          = shadow_q;
            dout_d[NCH-1]   = din;
            frame_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == StLock);
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed self-checking bench for tdm_demux_rx with NCH=4, WIDTH=8.
module tb_tdm_demux_rx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        fsync;
    logic [31:0] dout;
    logic        frame_valid;
    logic        locked;
    logic [1:0]  slot;
    logic        sync_err;

    int n_checks;
    int n_fail;
    int fv_cnt;
    int err_cnt;

    tdm_demux_rx #(
        .WIDTH (8),
        .NCH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic f, input logic [7:0] d);
        @(negedge clk);
        din_valid = v;
        fsync     = f;
        din       = d;
        @(posedge clk);
        #1;
        fv_cnt  += int'(frame_valid);
        err_cnt += int'(sync_err);
    endtask

    task automatic do_reset(input int edges);
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        fsync     = 1'b0;
        din       = 8'h00;
        repeat (edges) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        fv_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset;
        do_reset(2);
        n_checks++;
        if (dout !== 32'h0) begin
            $display("FAIL reset_dout: got %h want %h", dout, 32'h0); n_fail++;
        end
        n_checks++;
        if ({frame_valid, locked, sync_err} !== 3'b000) begin
            $display("FAIL reset_flags: got fv/lk/err=%b want 000",
                     {frame_valid, locked, sync_err}); n_fail++;
        end
        n_checks++;
        if (slot !== 2'd0) begin
            $display("FAIL reset_slot: got %0d want 0", slot); n_fail++;
        end
    endtask

    task automatic test_lock;
        fv_cnt = 0; err_cnt = 0;
        step(1, 1, 8'hA1);
        n_checks++;
        if (locked !== 1'b1 || slot !== 2'd1) begin
            $display("FAIL lock_first: got locked=%b slot=%0d want 1 1", locked, slot); n_fail++;
        end
        step(1, 0, 8'hB2);
        step(1, 0, 8'hC3);
        step(1, 0, 8'hD4);
        n_checks++;
        if (frame_valid !== 1'b1 || dout !== 32'hD4C3B2A1) begin
            $display("FAIL lock_frame: got fv=%b dout=%h want 1 d4c3b2a1", frame_valid, dout);
            n_fail++;
        end
        n_checks++;
        if (locked !== 1'b1 || slot !== 2'd0) begin
            $display("FAIL lock_state: got locked=%b slot=%0d want 1 0", locked, slot); n_fail++;
        end
        step(0, 0, 8'hFF);
        n_checks++;
        if (frame_valid !== 1'b0 || fv_cnt != 1) begin
            $display("FAIL lock_pulse: got fv=%b count=%0d want 0 1", frame_valid, fv_cnt);
            n_fail++;
        end
    endtask

    task automatic test_gapped_back_to_back;
        fv_cnt = 0; err_cnt = 0;
        step(1, 1, 8'hA1);
        step(0, 0, 8'h00);
        step(1, 0, 8'hB2);
        repeat (2) step(0, 1, 8'hEE);
        step(1, 0, 8'hC3);
        repeat (3) step(0, 0, 8'hEE);
        n_checks++;
        if (fv_cnt != 0 || slot !== 2'd3) begin
            $display("FAIL gap_partial: got count=%0d slot=%0d want 0 3", fv_cnt, slot); n_fail++;
        end
        step(1, 0, 8'hD4);
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        n_checks++;
        if (fv_cnt != 2 || err_cnt != 0) begin
            $display("FAIL b2b_counts: got fv=%0d err=%0d want 2 0", fv_cnt, err_cnt); n_fail++;
        end
        n_checks++;
        if (dout !== 32'h44332211) begin
            $display("FAIL b2b_dout: got %h want 44332211", dout); n_fail++;
        end
    endtask

    task automatic test_early_sync;
        fv_cnt = 0; err_cnt = 0;
        step(1, 1, 8'hA1);
        step(1, 0, 8'hB2);
        step(1, 1, 8'h55);
        n_checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || slot !== 2'd1) begin
            $display("FAIL early_err: got err=%b fv=%b slot=%0d want 1 0 1",
                     sync_err, frame_valid, slot); n_fail++;
        end
        n_checks++;
        if (dout !== 32'h44332211 || locked !== 1'b1) begin
            $display("FAIL early_hold: got dout=%h locked=%b want 44332211 1", dout, locked);
            n_fail++;
        end
        step(1, 0, 8'h66);
        n_checks++;
        if (sync_err !== 1'b0) begin
            $display("FAIL early_pulse: got err=%b want 0", sync_err); n_fail++;
        end
        step(1, 0, 8'h77);
        step(1, 0, 8'h88);
        n_checks++;
        if (dout !== 32'h88776655 || fv_cnt != 1 || err_cnt != 1 || locked !== 1'b1) begin
            $display("FAIL early_frame: got dout=%h fv=%0d err=%0d lk=%b want 88776655 1 1 1",
                     dout, fv_cnt, err_cnt, locked); n_fail++;
        end
    endtask

    task automatic test_missing_sync;
        fv_cnt = 0; err_cnt = 0;
        step(1, 0, 8'h99);
        n_checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0) begin
            $display("FAIL miss_err: got err=%b locked=%b slot=%0d want 1 0 0",
                     sync_err, locked, slot); n_fail++;
        end
        n_checks++;
        if (dout !== 32'h88776655) begin
            $display("FAIL miss_hold: got %h want 88776655", dout); n_fail++;
        end
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        n_checks++;
        if (err_cnt != 1 || locked !== 1'b0) begin
            $display("FAIL miss_ignore: got err=%0d locked=%b want 1 0", err_cnt, locked);
            n_fail++;
        end
        step(1, 1, 8'h10);
        step(1, 0, 8'h20);
        step(1, 0, 8'h30);
        step(1, 0, 8'h40);
        n_checks++;
        if (dout !== 32'h40302010 || locked !== 1'b1 || fv_cnt != 1) begin
            $display("FAIL miss_relock: got dout=%h lk=%b fv=%0d want 40302010 1 1",
                     dout, locked, fv_cnt); n_fail++;
        end
    endtask

    task automatic test_hunt_ignore;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'(8'h60 + i));
        end
        n_checks++;
        if (locked !== 1'b0 || err_cnt != 0 || dout !== 32'h0 || slot !== 2'd0) begin
            $display("FAIL hunt_ignore: got lk=%b err=%0d dout=%h slot=%0d want 0 0 0 0",
                     locked, err_cnt, dout, slot); n_fail++;
        end
    endtask

    task automatic test_reset_midframe;
        step(1, 1, 8'h10);
        step(1, 0, 8'h20);
        step(1, 0, 8'h30);
        step(1, 0, 8'h40);
        step(1, 1, 8'hA1);
        step(1, 0, 8'hB2);
        n_checks++;
        if (dout !== 32'h40302010) begin
            $display("FAIL mid_pre: got %h want 40302010", dout); n_fail++;
        end
        do_reset(1);
        step(1, 0, 8'hC3);
        step(1, 0, 8'hD4);
        n_checks++;
        if (dout !== 32'h0 || locked !== 1'b0 || fv_cnt != 0 || slot !== 2'd0) begin
            $display("FAIL mid_reset: got dout=%h lk=%b fv=%0d slot=%0d want 0 0 0 0",
                     dout, locked, fv_cnt, slot); n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        fv_cnt    = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        fsync     = 1'b0;
        test_reset();
        test_lock();
        test_gapped_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_hunt_ignore();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
